mc_seq: RTL and testbench
=========================

Name: mc_seq

Overview:
- State sequencer for the multicycle RV32I core.
- Steps each instruction through fetch, decode, execute, memory and writeback. Issues instruction and data bus requests with a req/ack handshake.
- Produces the per-phase write enables (ir_we, pc_we, rf_we_en). rf_we_en gates the combinational decoder's rf_we.
- Adds a bus watchdog, a sticky trap state and a retired-instruction counter.

Parameters:
- BUS_TIMEOUT, 255: stall cycles tolerated on an outstanding bus request before a fault; legal range 1..255.
- CNT_W, 32: width of retire_cnt.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  inst[6:0] from the instruction register
- halt  in  1  debug halt; suppresses starting a new fetch
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
- dmem_ack  in  1  data access complete
- ir_we  out  1  latch the instruction register
- pc_we  out  1  update PC from the npc mux
- rf_we_en  out  1  register-file write enable, qualifies the decoder's rf_we
- instr_done  out  1  one-cycle pulse when an instruction retires
- retire_cnt  out  CNT_W  retired-instruction count
- trap  out  1  sticky: illegal opcode or bus fault
- bus_fault  out  1  sticky: watchdog expired
- state  out  3  current state, for debug

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=S_IF, pending=0, wd_cnt=0, retire_cnt=0, trap=0, bus_fault=0.
  - All combinational outputs evaluate to 0 in that state.
  - Reset asserted mid-transaction abandons the request. No write enable may assert in the reset cycle.
- States (3-bit encoding): S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_TRAP=7. Only the state register is clocked state; outputs decode combinationally from state, pending and ack.
- S_IF:
  - imem_req = pending | ~halt.
  - pending sets when imem_req=1 and imem_ack=0, and clears on ack. Once raised, a request holds until ack regardless of halt.
  - On imem_req & imem_ack: ir_we=1 for that cycle, next state S_ID.
  - halt=1 with pending=0: stay in S_IF, imem_req=0.
- S_ID: one cycle.
  - Opcode not in {R, I, LOAD, S, B, LUI, AUIPC, JAL, JALR} -> S_TRAP and set trap.
  - Otherwise -> S_EX.
- S_EX: one cycle.
  - B: pc_we=1, instr_done=1, next S_IF.
  - LOAD/S: next S_MEM.
  - All other legal opcodes: next S_WB.
- S_MEM:
  - dmem_req=1 until dmem_ack; dmem_we=(opcode==S).
  - On ack: LOAD -> S_WB. S -> pc_we=1, instr_done=1, next S_IF.
- S_WB: one cycle.
  - rf_we_en=1, pc_we=1, instr_done=1, next S_IF.
- S_TRAP: terminal until reset. All requests and enables are 0, trap=1.
- Latency with single-cycle ack, in cycles from entering S_IF to retire:
  - B: 3
  - R/I/LUI/AUIPC/JAL/JALR: 4
  - S: 4
  - LOAD: 5
  - Each extra ack-wait cycle adds 1.
- Watchdog:
  - wd_cnt increments each cycle that a request (imem_req or dmem_req) is high with no ack.
  - wd_cnt clears on ack and on every state change.
  - When wd_cnt==BUS_TIMEOUT-1 and there is still no ack: next S_TRAP, and set bus_fault and trap. The request drops the following cycle.
  - Ack in the same cycle as expiry: ack wins, no fault.
- retire_cnt increments by 1 on every instr_done and wraps from all-ones to 0 silently.
- At most one of ir_we, pc_we, rf_we_en is active per cycle, except the S_WB cycle (pc_we+rf_we_en). These two are required together in S_WB.
- The halt input never affects S_ID..S_WB; an instruction in flight always completes.

Decomposition:
- Shared package/header (defines.vh):
  - opcode constants OP_R..OP_JALR
  - state encodings S_IF..S_TRAP
- Natural sub-module: mc_bus_watchdog, holding wd_cnt and the expiry compare.
  - Inputs: req, ack, clr.
  - Output: expire.
  - Parameter: BUS_TIMEOUT.
- The FSM, enables and retire counter stay in mc_seq.

Test Plan:
- ADD (opcode 0110011), imem_ack=1 every cycle -> states 0,1,2,4; ir_we in cycle 0; rf_we_en=pc_we=instr_done in cycle 3; retire_cnt 0->1.
- LW (0000011), dmem_ack delayed 2 cycles -> dmem_req high 3 cycles with dmem_we=0, then S_WB; retire after 7 cycles total.
- Stream SW then BEQ (0100011, 1100011) -> SW retires at cycle 4 with pc_we in S_MEM and rf_we_en never 1; BEQ retires in S_EX 3 cycles later.
- Opcode 7'b0000000 -> S_ID then S_TRAP; trap=1 stays set; no imem_req for 20 cycles; rst_n low returns state=0, trap=0.
- BUS_TIMEOUT=4, imem_ack held 0 -> imem_req high 4 cycles, then state=7 and bus_fault=1. Repeat with ack in the 4th cycle -> no fault, ir_we=1.
- halt=1 after an unacked request -> imem_req stays 1 until ack. Then, with halt still 1, the core idles in S_IF with imem_req=0. Also: rst_n pulsed mid-S_MEM -> dmem_req drops immediately, retire_cnt=0.

Source files
------------

// File: rtl/mc_seq_pkg.sv
// Shared constants for the multicycle RV32I sequencer: opcodes, state encoding, widths.
package mc_seq_pkg;

  localparam int unsigned OP_W = 7;
  localparam int unsigned ST_W = 3;
  localparam int unsigned WD_W = 8;

  localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I     = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_S     = 7'b0100011;
  localparam logic [OP_W-1:0] OP_B     = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR  = 7'b1100111;

  typedef enum logic [ST_W-1:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_seq_if.sv
// Instruction and data bus req/ack handshake between the sequencer and memory.
interface mc_seq_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, input imem_ack, output dmem_req, output dmem_we, input dmem_ack);
  modport slave  (input imem_req, output imem_ack, input dmem_req, input dmem_we, output dmem_ack);
endinterface

// File: rtl/mc_seq_bus_watchdog.sv
// Counts unacknowledged request cycles and flags expiry on the last tolerated stall cycle.
module mc_bus_watchdog
  import mc_seq_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  input  logic clr,
  output logic expire
);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (clr || ack) begin
      wd_cnt <= '0;
    end else if (req) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // A same-cycle ack always beats expiry.
  assign expire = req && !ack && (wd_cnt == WD_W'(BUS_TIMEOUT - 1));

endmodule

// File: rtl/mc_seq.sv
// Multicycle RV32I state sequencer: fetch/decode/execute/memory/writeback with
// bus handshakes, watchdog-driven bus fault, sticky trap and retire counter.
module mc_seq
  import mc_seq_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic             halt,
  mc_seq_if.master         bus,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we_en,
  output logic             instr_done,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             trap,
  output logic             bus_fault,
  output logic [ST_W-1:0]  state
);

  state_e state_q, state_d;
  logic   pending;
  logic   fetch_req, mem_req, bus_ack, expire, st_change;

  // Requests are forced low while reset is held so nothing leaks out of the reset cycle.
  assign fetch_req = rst_n && (state_q == S_IF) && (pending || !halt);
  assign mem_req   = rst_n && (state_q == S_MEM);
  assign bus_ack   = (fetch_req && bus.imem_ack) || (mem_req && bus.dmem_ack);
  assign st_change = (state_d != state_q);
  assign state     = state_q;

  mc_bus_watchdog #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (fetch_req || mem_req),
    .ack    (bus_ack),
    .clr    (st_change),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IF;
      pending    <= 1'b0;
      retire_cnt <= '0;
      trap       <= 1'b0;
      bus_fault  <= 1'b0;
    end else begin
      state_q <= state_d;
      pending <= fetch_req && !bus.imem_ack && !expire;
      if (instr_done)        retire_cnt <= retire_cnt + CNT_W'(1);
      if (state_d == S_TRAP) trap       <= 1'b1;
      if (expire)            bus_fault  <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we_en     = 1'b0;
    instr_done   = 1'b0;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    case (state_q)
      S_IF: begin
        bus.imem_req = fetch_req;
        if (fetch_req && bus.imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end else if (expire) begin
          state_d = S_TRAP;
        end
      end
      S_ID: state_d = op_legal(opcode) ? S_EX : S_TRAP;
      S_EX: begin
        if (opcode == OP_B) begin
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_d    = S_IF;
        end else if (opcode == OP_LOAD || opcode == OP_S) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        bus.dmem_req = mem_req;
        bus.dmem_we  = mem_req && (opcode == OP_S);
        if (mem_req && bus.dmem_ack) begin
          if (opcode == OP_S) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (expire) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        rf_we_en   = 1'b1;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_IF;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_mc_seq.sv
// Bench for mc_seq: random instruction stream against a per-cycle scoreboard,
// plus directed halt, reset, watchdog and illegal-opcode scenarios.
module tb_mc_seq;
  import mc_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        halt;
  logic        ir_we, pc_we, rf_we_en, instr_done, trap, bus_fault;
  logic [31:0] retire_cnt;
  logic [2:0]  state;

  mc_seq_if bus();

  mc_seq #(.BUS_TIMEOUT(4), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .halt       (halt),
    .bus        (bus),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .rf_we_en   (rf_we_en),
    .instr_done (instr_done),
    .retire_cnt (retire_cnt),
    .trap       (trap),
    .bus_fault  (bus_fault),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        ir, pc, rf, done, ireq, dreq, dwe;
    logic [31:0] rc;
  } exp_t;

  typedef struct packed {
    logic [6:0] op;
    logic       ia, da;
  } drv_t;

  exp_t exp_q[$];
  drv_t drv_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   retired  = 0;
  logic mon_en   = 1'b0;
  exp_t mon_e, mon_a;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", name, got, want, $time);
    end
  endtask

  task automatic add(input logic [2:0] st, input logic ir, input logic pc, input logic rf,
                     input logic done, input logic ireq, input logic dreq, input logic dwe,
                     input logic [6:0] op, input logic ia, input logic da);
    exp_t e;
    drv_t d;
    e = '{st: st, ir: ir, pc: pc, rf: rf, done: done, ireq: ireq, dreq: dreq, dwe: dwe,
          rc: 32'(retired)};
    d = '{op: op, ia: ia, da: da};
    exp_q.push_back(e);
    drv_q.push_back(d);
  endtask

  // Reference: one record per cycle, fetch waits di cycles, memory waits dd cycles.
  task automatic push_instr(input logic [6:0] op, input int di, input int dd);
    bit is_mem, is_st;
    is_mem = (op == OP_LOAD) || (op == OP_S);
    is_st  = (op == OP_S);
    for (int k = 0; k <= di; k++)
      add(3'd0, k == di, 0, 0, 0, 1, 0, 0, op, k == di, 0);
    add(3'd1, 0, 0, 0, 0, 0, 0, 0, op, 0, 0);
    if (op == OP_B) begin
      add(3'd2, 0, 1, 0, 1, 0, 0, 0, op, 0, 0);
    end else begin
      add(3'd2, 0, 0, 0, 0, 0, 0, 0, op, 0, 0);
      if (is_mem)
        for (int k = 0; k <= dd; k++)
          add(3'd3, 0, is_st && k == dd, 0, is_st && k == dd, 0, 1, is_st, op, 0, k == dd);
      if (!is_st)
        add(3'd4, 0, 1, 1, 1, 0, 0, 0, op, 0, 0);
    end
    retired++;
  endtask

  task automatic run_stream();
    drv_t d;
    while (drv_q.size() > 0) begin
      @(posedge clk); #1;
      d            = drv_q.pop_front();
      halt         = 1'b0;
      mon_en       = 1'b1;
      opcode       = d.op;
      bus.imem_ack = d.ia;
      bus.dmem_ack = d.da;
    end
    @(posedge clk); #1;
    mon_en       = 1'b0;
    halt         = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  // Scoreboard monitor: compares every observed cycle against the next expected record.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_a = '{st: state, ir: ir_we, pc: pc_we, rf: rf_we_en, done: instr_done,
                ireq: bus.imem_req, dreq: bus.dmem_req, dwe: bus.dmem_we, rc: retire_cnt};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_underrun got=%h expected=<none>", mon_a);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          n_errors++;
          $display("FAIL sb_cycle state got=%0d expected=%0d fields got=%h expected=%h @%0t",
                   mon_a.st, mon_e.st, mon_a, mon_e, $time);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  logic [6:0] legal_ops [9];

  initial begin
    legal_ops = '{OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    rst_n = 1'b0; halt = 1'b0; opcode = OP_R;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;

    // Reset: everything quiet even with halt low.
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_enables", 32'({ir_we, pc_we, rf_we_en, instr_done, bus.dmem_req}), 32'd0);
    check("rst_retire_cnt", retire_cnt, 32'd0);
    check("rst_flags", 32'({trap, bus_fault}), 32'd0);
    halt = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;

    // Directed stream then random stream, all scoreboarded.
    push_instr(OP_R, 0, 0);
    push_instr(OP_LOAD, 0, 2);
    push_instr(OP_S, 0, 0);
    push_instr(OP_B, 0, 0);
    for (int i = 0; i < 40; i++)
      push_instr(legal_ops[$urandom_range(0, 8)], int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)));
    run_stream();
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("halt_idle_req", 32'(bus.imem_req), 32'd0);
    check("halt_idle_state", 32'(state), 32'd0);
    check("retire_total", retire_cnt, 32'(retired));

    // A raised fetch request survives halt until acked; afterwards halt idles the core.
    @(posedge clk); #1; opcode = OP_R; halt = 1'b0;
    @(posedge clk); #1; halt = 1'b1;
    @(negedge clk);
    check("halt_pending_req", 32'(bus.imem_req), 32'd1);
    @(posedge clk); #1; bus.imem_ack = 1'b1;
    @(negedge clk);
    check("halt_ack_ir_we", 32'(ir_we), 32'd1);
    @(posedge clk); #1; bus.imem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("halt_after_req", 32'(bus.imem_req), 32'd0);
    check("halt_after_state", 32'(state), 32'd0);
    check("halt_after_cnt", retire_cnt, 32'(retired + 1));

    // Reset in the middle of a load abandons the data request.
    @(posedge clk); #1; opcode = OP_LOAD; halt = 1'b0; bus.imem_ack = 1'b1;
    @(posedge clk); #1; bus.imem_ack = 1'b0; halt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mem_state", 32'(state), 32'd3);
    check("mem_req_load", 32'({bus.dmem_req, bus.dmem_we}), 32'b10);
    #2; rst_n = 1'b0; #1;
    check("mem_rst_req", 32'(bus.dmem_req), 32'd0);
    check("mem_rst_state", 32'(state), 32'd0);
    check("mem_rst_cnt", retire_cnt, 32'd0);

    // Watchdog expiry with the fetch never acked.
    halt = 1'b0; opcode = OP_R;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wd_req_held", 32'(bus.imem_req), 32'd1);
    end
    @(negedge clk);
    check("wd_state", 32'(state), 32'd7);
    check("wd_flags", 32'({bus_fault, trap, bus.imem_req}), 32'b110);

    // Ack on the last tolerated cycle wins over expiry.
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.imem_ack = 1'b1;
    @(negedge clk);
    check("wd_late_ack_ir_we", 32'({ir_we, bus.imem_req}), 32'b11);
    @(posedge clk); #1; bus.imem_ack = 1'b0;
    @(negedge clk);
    check("wd_late_ack_state", 32'(state), 32'd1);
    check("wd_late_ack_flags", 32'({bus_fault, trap}), 32'd0);

    // Illegal opcode traps permanently until reset.
    @(negedge clk); rst_n = 1'b0; opcode = 7'b0000000; bus.imem_ack = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; bus.imem_ack = 1'b0;
    @(negedge clk);
    check("ill_decode_state", 32'(state), 32'd1);
    @(negedge clk);
    check("ill_trap_state", 32'({state, trap}), 32'({3'd7, 1'b1}));
    repeat (20) begin
      @(negedge clk);
      check("ill_trap_idle", 32'({bus.imem_req, trap, ir_we, pc_we}), 32'b0100);
    end
    rst_n = 1'b0; #1;
    check("ill_rst_clear", 32'({state, trap}), 32'd0);

    #20;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
